// File: rtl/approx_adder_error_monitor_if.sv
// approx_adder_error_monitor_if: control, adder-under-test and metric signals of the error monitor
interface approx_adder_error_monitor_if #(
  parameter int N = 16,
  parameter int CNT_W = 24
);
  logic                    start_i;
  logic                    clr_i;
  logic [CNT_W-1:0]        num_vec_i;
  logic [N-1:0]            a_o;
  logic [N-1:0]            b_o;
  logic [N-1:0]            approx_sum_i;
  logic                    approx_co_i;
  logic                    busy_o;
  logic                    done_o;
  logic [CNT_W-1:0]        err_cnt_o;
  logic [N+CNT_W:0]        sum_ed_o;
  logic [N:0]              max_ed_o;
  logic [2*N+1+CNT_W:0]    sum_sq_ed_o;
  modport master (
    output start_i, clr_i, num_vec_i, approx_sum_i, approx_co_i,
    input  a_o, b_o, busy_o, done_o, err_cnt_o, sum_ed_o, max_ed_o, sum_sq_ed_o
  );
  modport slave (
    input  start_i, clr_i, num_vec_i, approx_sum_i, approx_co_i,
    output a_o, b_o, busy_o, done_o, err_cnt_o, sum_ed_o, max_ed_o, sum_sq_ed_o
  );
endinterface

// File: rtl/approx_adder_error_monitor.sv
// approx_adder_error_monitor: LFSR-driven ER/MED/NMED characterisation of an external approximate adder; `APPROX_MON_SQERR_EN adds the squared-error accumulator
module approx_adder_error_monitor #(
  parameter int          N             = 16,
  parameter int          CNT_W         = 24,
  parameter logic [31:0] SEED          = 32'h1,
  parameter bit          INCLUDE_CARRY = 1'b0
) (
  input logic clk,
  input logic rst_n,
  approx_adder_error_monitor_if.slave bus
);
  localparam logic [31:0] SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam int SW = N + 1 + CNT_W;
  localparam int QW = 2 * N + 2 + CNT_W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t           state;
  logic [31:0]      lfsr, lfsr_next;
  logic [CNT_W-1:0] num_vec, issued, err_cnt;
  logic             drain_cnt, busy, done;
  logic             go, clr;
  logic             s0_v, s1_v, s1_mis;
  logic [N:0]       s0_exact, s0_approx, d_exact, d_approx, ed, s1_ed, max_ed;
  logic [SW-1:0]    sum_ed;
  logic [QW-1:0]    sum_sq_ed;
  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);
  assign go  = bus.start_i & (state == IDLE || state == DONE);
  assign clr = bus.clr_i & (state == IDLE || state == DONE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= SEED_NZ;
      num_vec   <= '0;
      issued    <= '0;
      drain_cnt <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (go) begin
      num_vec   <= bus.num_vec_i;
      issued    <= '0;
      drain_cnt <= 1'b0;
      state     <= (bus.num_vec_i == '0) ? DONE : RUN;
      busy      <= (bus.num_vec_i != '0);
      done      <= (bus.num_vec_i == '0);
    end else if (state == RUN) begin
      lfsr   <= lfsr_next;
      issued <= issued + 1'b1;
      if (issued == num_vec - 1'b1) state <= DRAIN;
    end else if (state == DRAIN) begin
      drain_cnt <= 1'b1;
      if (drain_cnt) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end
  always_comb begin
    d_exact  = INCLUDE_CARRY ? s0_exact : {1'b0, s0_exact[N-1:0]};
    d_approx = INCLUDE_CARRY ? s0_approx : {1'b0, s0_approx[N-1:0]};
    ed       = (d_exact >= d_approx) ? d_exact - d_approx : d_approx - d_exact;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v      <= 1'b0;
      s1_v      <= 1'b0;
      s0_exact  <= '0;
      s0_approx <= '0;
      s1_ed     <= '0;
      s1_mis    <= 1'b0;
    end else begin
      s0_v      <= (state == RUN);
      s1_v      <= s0_v;
      s0_exact  <= {1'b0, bus.a_o} + {1'b0, bus.b_o};
      s0_approx <= {bus.approx_co_i, bus.approx_sum_i};
      s1_ed     <= ed;
      s1_mis    <= (ed != '0);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      sum_ed  <= '0;
      max_ed  <= '0;
    end else if (go || clr) begin
      err_cnt <= '0;
      sum_ed  <= '0;
      max_ed  <= '0;
    end else if (s1_v) begin
      err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, s1_mis};
      sum_ed  <= sum_ed + {{CNT_W{1'b0}}, s1_ed};
      max_ed  <= (s1_ed > max_ed) ? s1_ed : max_ed;
    end
  end
`ifdef APPROX_MON_SQERR_EN
  logic [2*N+1:0] sq;
  assign sq = {{(N+1){1'b0}}, s1_ed} * {{(N+1){1'b0}}, s1_ed};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_sq_ed <= '0;
    else if (go || clr) sum_sq_ed <= '0;
    else if (s1_v) sum_sq_ed <= sum_sq_ed + {{CNT_W{1'b0}}, sq};
  end
`else
  assign sum_sq_ed = '0;
`endif
  assign bus.a_o         = lfsr[N-1:0];
  assign bus.b_o         = lfsr[16+N-1:16];
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.err_cnt_o   = err_cnt;
  assign bus.sum_ed_o    = sum_ed;
  assign bus.max_ed_o    = max_ed;
  assign bus.sum_sq_ed_o = sum_sq_ed;
endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// tb_approx_adder_error_monitor: randomized runs of two monitors (carry excluded/included) against an arithmetic reference model
module tb_approx_adder_error_monitor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic [23:0] num_vec = '0;
  int          mode = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_lfsr = 32'h1;
  longint unsigned e_err[2], e_sum[2], e_max[2], e_sq[2];
  longint unsigned carries;
  always #5 clk = ~clk;
  approx_adder_error_monitor_if #(.N(16), .CNT_W(24)) if0 ();
  approx_adder_error_monitor_if #(.N(16), .CNT_W(24)) if1 ();
  function automatic logic [16:0] adder(input logic [15:0] a, input logic [15:0] b, input int m);
    logic [16:0] s;
    logic [12:0] hi;
    s  = {1'b0, a} + {1'b0, b};
    hi = {1'b0, a[15:4]} + {1'b0, b[15:4]};
    return (m == 1) ? (s ^ 17'd1) : (m == 2) ? {1'b0, s[15:0]} : (m == 3) ? {hi, a[3:0] | b[3:0]} : s;
  endfunction
  assign if0.start_i = start;
  assign if0.clr_i = clr;
  assign if0.num_vec_i = num_vec;
  assign {if0.approx_co_i, if0.approx_sum_i} = adder(if0.a_o, if0.b_o, mode);
  assign if1.start_i = start;
  assign if1.clr_i = clr;
  assign if1.num_vec_i = num_vec;
  assign {if1.approx_co_i, if1.approx_sum_i} = adder(if1.a_o, if1.b_o, mode);
  approx_adder_error_monitor #(.N(16), .CNT_W(24), .SEED(32'h0), .INCLUDE_CARRY(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  approx_adder_error_monitor #(.N(16), .CNT_W(24), .SEED(32'h0), .INCLUDE_CARRY(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction
  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      e_err[k] = 0; e_sum[k] = 0; e_max[k] = 0; e_sq[k] = 0;
    end
    carries = 0;
  endtask
  task automatic model_run(input int n);
    logic [15:0] a, b;
    longint ex, ap, x, y, ed;
    model_clear();
    for (int i = 0; i < n; i++) begin
      a  = m_lfsr[15:0];
      b  = m_lfsr[31:16];
      ex = longint'(a) + longint'(b);
      ap = longint'(adder(a, b, mode));
      if (ex >= 65536) carries++;
      for (int k = 0; k < 2; k++) begin
        x  = (k == 1) ? ex : ex % 65536;
        y  = (k == 1) ? ap : ap % 65536;
        ed = (x > y) ? x - y : y - x;
        if (ed != 0) e_err[k]++;
        e_sum[k] += ed;
        if (ed > e_max[k]) e_max[k] = ed;
`ifdef APPROX_MON_SQERR_EN
        e_sq[k] += ed * ed;
`endif
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  endtask
  task automatic check_metrics();
    check("err_nc", if0.err_cnt_o, e_err[0]);
    check("sum_nc", if0.sum_ed_o, e_sum[0]);
    check("max_nc", if0.max_ed_o, e_max[0]);
    check("sq_nc", if0.sum_sq_ed_o, e_sq[0]);
    check("err_c", if1.err_cnt_o, e_err[1]);
    check("sum_c", if1.sum_ed_o, e_sum[1]);
    check("max_c", if1.max_ed_o, e_max[1]);
    check("sq_c", if1.sum_sq_ed_o, e_sq[1]);
  endtask
  task automatic run(input int n, input int poke);
    int cyc;
    check("a_pre", if0.a_o, m_lfsr[15:0]);
    check("b_pre", if1.b_o, m_lfsr[31:16]);
    num_vec = 24'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    if (n > 0) check("busy", if0.busy_o, 1);
    while (!if0.done_o && cyc < n + 10) begin
      if (cyc == poke) begin
        start = 1'b1; clr = 1'b1; num_vec = 24'd5;
      end
      @(negedge clk);
      start = 1'b0;
      clr = 1'b0;
      cyc++;
    end
    check("latency", longint'(cyc), (n == 0) ? 1 : longint'(n + 3));
    check("done_c", if1.done_o, 1);
    model_run(n);
    check_metrics();
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", if0.busy_o, 0);
    check("rst_done", if0.done_o, 0);
    check("rst_a", if0.a_o, 16'h0001);
    check("rst_b", if0.b_o, 16'h0000);
    model_clear();
    check_metrics();
    rst_n = 1'b1;
    @(negedge clk);
    mode = 0; run(1000, -1);
    mode = 1; run(100, -1);
    mode = 2; run(200, -1);
    check("carry_err", if1.err_cnt_o, carries);
    check("carry_max", if1.max_ed_o, 65536);
    run(0, -1);
    check("n0_a", if0.a_o, m_lfsr[15:0]);
    mode = 3; run(60, 20);
    for (int r = 0; r < 4; r++) begin
      mode = int'($urandom_range(0, 3));
      run(int'($urandom_range(1, 300)), -1);
    end
    mode = 3; run(50, -1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    check_metrics();
    check("clr_done", if0.done_o, 1);
    run(50, -1);
    num_vec = 24'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_busy", if0.busy_o, 0);
    check("mr_a", if0.a_o, 16'h0001);
    check("mr_b", if1.b_o, 16'h0000);
    model_clear();
    check_metrics();
    rst_n = 1'b1;
    m_lfsr = 32'h1;
    @(negedge clk);
    run(40, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
